// File: rtl/gpio_funcs_pipe.sv
// rtl/gpio_funcs_pipe.sv - pipelined per-lane add/sub/xor/and unit with valid/ready flow control
// Optional feature macro: GPIO_FUNCS_SAT_EN (saturating ADD/SUB when defined).
module gpio_funcs_pipe #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [NCH*DW-1:0] in_a,
    input  logic [NCH*DW-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_flag,
    output logic [15:0]       out_count,
    output logic              busy
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [NCH*DW-1:0] lane_res;
    logic [NCH-1:0]    lane_flag;

    logic [LAT-1:0]    stg_valid;
    logic [LAT-1:0]    stg_load;
    logic [NCH*DW-1:0] stg_data [LAT];
    logic [NCH-1:0]    stg_flag [LAT];
    logic [15:0]       count_q;

    // Per-lane operation; each lane is isolated so no carry crosses lanes.
    always_comb begin
        logic [DW-1:0] a_l;
        logic [DW-1:0] b_l;
        logic [DW:0]   sum;
        logic [DW:0]   diff;
        logic [DW-1:0] r;
        logic          f;
        lane_res  = '0;
        lane_flag = '0;
        for (int i = 0; i < NCH; i++) begin
            a_l  = in_a[i*DW +: DW];
            b_l  = in_b[i*DW +: DW];
            sum  = {1'b0, a_l} + {1'b0, b_l};
            diff = {1'b0, a_l} - {1'b0, b_l};
            r    = '0;
            f    = 1'b0;
            case (in_op)
                OP_ADD: begin
                    f = sum[DW];
`ifdef GPIO_FUNCS_SAT_EN
                    r = f ? {DW{1'b1}} : sum[DW-1:0];
`else
                    r = sum[DW-1:0];
`endif
                end
                OP_SUB: begin
                    f = diff[DW];
`ifdef GPIO_FUNCS_SAT_EN
                    r = f ? '0 : diff[DW-1:0];
`else
                    r = diff[DW-1:0];
`endif
                end
                OP_XOR: begin
                    r = a_l ^ b_l;
                    f = (r == '0);
                end
                default: begin
                    r = a_l & b_l;
                    f = (r == '0);
                end
            endcase
            lane_res[i*DW +: DW] = r;
            lane_flag[i]         = f;
        end
    end

    // A stage may load when it is empty or its contents move on; bubbles collapse.
    always_comb begin
        stg_load = '0;
        stg_load[LAT-1] = !stg_valid[LAT-1] || out_ready;
        for (int k = LAT-2; k >= 0; k--) begin
            stg_load[k] = !stg_valid[k] || stg_load[k+1];
        end
    end

    assign in_ready = stg_load[0];

    // Pipeline registers: stage 0 captures results, later stages shift forward.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stg_valid <= '0;
            for (int k = 0; k < LAT; k++) begin
                stg_data[k] <= '0;
                stg_flag[k] <= '0;
            end
        end else begin
            if (stg_load[0]) begin
                stg_valid[0] <= in_valid;
                if (in_valid) begin
                    stg_data[0] <= lane_res;
                    stg_flag[0] <= lane_flag;
                end
            end
            for (int k = 1; k < LAT; k++) begin
                if (stg_load[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    if (stg_valid[k-1]) begin
                        stg_data[k] <= stg_data[k-1];
                        stg_flag[k] <= stg_flag[k-1];
                    end
                end
            end
        end
    end

    // Completed-transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else if (stg_valid[LAT-1] && out_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign out_valid = stg_valid[LAT-1];
    assign out_data  = stg_data[LAT-1];
    assign out_flag  = stg_flag[LAT-1];
    assign out_count = count_q;
    assign busy      = |stg_valid;

endmodule

// File: tb/tb_gpio_funcs_pipe.sv
// tb/tb_gpio_funcs_pipe.sv - self-checking bench for gpio_funcs_pipe against a queue reference model
module tb_gpio_funcs_pipe;

    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int LAT = 2;
    localparam int W   = NCH * DW;

    logic           clk = 1'b0;
    logic           nreset;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [NCH-1:0] out_flag;
    logic [15:0]    out_count;
    logic           busy;

    gpio_funcs_pipe #(.DW(DW), .NCH(NCH), .LAT(LAT)) dut (
        .clk(clk), .nreset(nreset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flag(out_flag),
        .out_count(out_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   d;
        logic [NCH-1:0] f;
        int             t;
    } beat_t;

    int             n_cmp = 0;
    int             n_fail = 0;
    beat_t          q[$];
    int             edge_no = 0;
    logic [15:0]    exp_count = '0;
    logic [W-1:0]   last_d;
    logic [NCH-1:0] last_f;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: lane arithmetic done on plain integers.
    function automatic beat_t model(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input int t);
        beat_t bt;
        int mask = (1 << DW) - 1;
        bt.d = '0;
        bt.f = '0;
        bt.t = t;
        for (int i = 0; i < NCH; i++) begin
            int x = int'(a[i*DW +: DW]);
            int y = int'(b[i*DW +: DW]);
            int r;
            bit f;
            case (op)
                2'd0: begin
                    f = (x + y) > mask;
                    r = (x + y) & mask;
`ifdef GPIO_FUNCS_SAT_EN
                    if (f) r = mask;
`endif
                end
                2'd1: begin
                    f = x < y;
                    r = (x - y) & mask;
`ifdef GPIO_FUNCS_SAT_EN
                    if (f) r = 0;
`endif
                end
                2'd2: begin r = x ^ y; f = (r == 0); end
                default: begin r = x & y; f = (r == 0); end
            endcase
            bt.d[i*DW +: DW] = DW'(r);
            bt.f[i] = f;
        end
        return bt;
    endfunction

    // One clock: drive, check outputs before the edge, update the model after it.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic rdy, output bit acc);
        bit exp_v;
        bit xfer;
        bit accept;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        @(negedge clk);
        exp_v = (q.size() > 0) && (edge_no >= q[0].t + LAT - 1);
        chk("in_ready", 64'(in_ready), 64'(rdy || (q.size() < LAT)));
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        chk("out_count", 64'(out_count), 64'(exp_count));
        if (out_valid && q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_flag", 64'(out_flag), 64'(q[0].f));
        end
        xfer   = out_valid && rdy;
        accept = v && in_ready;
        if (xfer && q.size() > 0) begin
            last_d = out_data;
            last_f = out_flag;
            void'(q.pop_front());
            exp_count = exp_count + 16'd1;
        end
        @(posedge clk);
        edge_no++;
        if (accept) q.push_back(model(op, a, b, edge_no));
        #1;
        acc = accept;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 2'd0, '0, '0, 1'b1, acc);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] rnd_w();
        return W'({$urandom, $urandom});
    endfunction

    initial begin
        bit           acc;
        int           n_acc;
        int           idx;
        logic [15:0]  c0;
        logic [W-1:0] ra [4];
        logic [W-1:0] rb [4];
        logic [1:0]   rop [4];

        nreset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_flag", 64'(out_flag), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); edge_no++;
        @(posedge clk); edge_no++;
        #1 nreset = 1'b1;

        // ADD: lane0 overflow, lane1 plain
        cycle(1'b1, 2'd0, 32'h0000_0C80, 32'h0000_2280, 1'b1, acc);
        drain();
`ifdef GPIO_FUNCS_SAT_EN
        chk("add_lane0", 64'(last_d[7:0]), 64'h0FF);
`else
        chk("add_lane0", 64'(last_d[7:0]), 64'h000);
`endif
        chk("add_lane1", 64'(last_d[15:8]), 64'h02E);
        chk("add_flags01", 64'(last_f[1:0]), 64'd1);

        // SUB: lane2 borrow
        cycle(1'b1, 2'd1, 32'h0010_0000, 32'h0022_0000, 1'b1, acc);
        drain();
`ifdef GPIO_FUNCS_SAT_EN
        chk("sub_lane2", 64'(last_d[23:16]), 64'h000);
`else
        chk("sub_lane2", 64'(last_d[23:16]), 64'h0EE);
`endif
        chk("sub_flag2", 64'(last_f[2]), 64'd1);

        // XOR of equal operands, AND of disjoint nibbles
        cycle(1'b1, 2'd2, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, acc);
        drain();
        chk("xor_data", 64'(last_d), 64'd0);
        chk("xor_flags", 64'(last_f), 64'hF);
        cycle(1'b1, 2'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, acc);
        drain();
        chk("and_data", 64'(last_d), 64'd0);
        chk("and_flags", 64'(last_f), 64'hF);

        // Stall: 4 beats offered with out_ready low, only LAT accepted
        for (int i = 0; i < 4; i++) begin
            ra[i] = rnd_w(); rb[i] = rnd_w(); rop[i] = 2'($urandom);
        end
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, rop[n_acc], ra[n_acc], rb[n_acc], 1'b0, acc);
            if (acc) n_acc++;
        end
        chk("stall_accepts", 64'(n_acc), 64'(LAT));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, '0, '0, 1'b0, acc);
        idx = n_acc;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            cycle(1'b1, rop[idx], ra[idx], rb[idx], 1'b1, acc);
            if (acc) idx++;
        end
        chk("stall_all_offered", 64'(idx), 64'd4);
        drain();

        // 16 back-to-back beats at full rate
        c0 = exp_count;
        for (int i = 0; i < 16; i++) cycle(1'b1, 2'($urandom), rnd_w(), rnd_w(), 1'b1, acc);
        drain();
        chk("b2b_count", 64'(out_count), 64'(c0 + 16'd16));
        chk("b2b_busy", 64'(busy), 64'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 2'($urandom), rnd_w(), rnd_w(), 1'($urandom_range(0, 3) != 0), acc);
        drain();

        // Reset mid-stream with two beats in flight
        cycle(1'b1, 2'd0, rnd_w(), rnd_w(), 1'b0, acc);
        cycle(1'b1, 2'd1, rnd_w(), rnd_w(), 1'b0, acc);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        nreset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_count", 64'(out_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        exp_count = '0;
        in_valid = 1'b0;
        @(posedge clk); edge_no++;
        #1 nreset = 1'b1;
        cycle(1'b1, 2'd2, 32'h1234_5678, 32'h0000_00FF, 1'b1, acc);
        drain();
        chk("post_rst_data", 64'(last_d), 64'h1234_5687);
        chk("post_rst_count", 64'(out_count), 64'd1);

        // Counter wrap: bring count to 0xFFFF, then one more transfer
        n_acc = 0;
        for (int i = 0; i < 70000 && n_acc < 65534; i++) begin
            cycle(1'b1, 2'd0, 32'h0101_0101, 32'h0202_0202, 1'b1, acc);
            if (acc) n_acc++;
        end
        drain();
        chk("count_ffff", 64'(out_count), 64'hFFFF);
        cycle(1'b1, 2'd3, rnd_w(), rnd_w(), 1'b1, acc);
        drain();
        chk("count_wrap", 64'(out_count), 64'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
